// File: rtl/mux_tree_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mux_tree_pipe_pkg
// Shared definitions for the pipelined channel multiplexer.
//   mode_t : select-source encoding driven on the top-level 'mode' port
//            MODE_DIRECT - channel taken from sel_in
//            MODE_SCAN   - round-robin over chan_mask starting at scan_ptr
//            MODE_HOLD   - repeat the select of the last accepted beat
//            MODE_RSVD   - reserved, treated exactly like MODE_DIRECT
// ---------------------------------------------------------------------------
package mux_tree_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

endpackage

// File: rtl/mux_rr_scan.sv
// ---------------------------------------------------------------------------
// mux_rr_scan
// Combinational cyclic first-set-bit finder: starting at bit 'ptr' and
// wrapping past CHANNELS-1 back to 0, report the first set bit of 'mask'.
// Shared with the round-robin arbiters, so it carries no state.
//   mask  : candidate bits, 1 = eligible
//   ptr   : starting position, must be < CHANNELS
//   found : at least one mask bit is set
//   idx   : position of the winning bit (0 when found = 0)
// ---------------------------------------------------------------------------
module mux_rr_scan #(
    parameter int CHANNELS = 16,
    localparam int SEL_W = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] mask,
    input  logic [SEL_W-1:0]    ptr,
    output logic                found,
    output logic [SEL_W-1:0]    idx
);

    always_comb begin
        found = |mask;
        idx   = '0;
        // Walk offsets from farthest to nearest so the nearest set bit is the
        // last one written and therefore wins.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            int c;
            c = int'(ptr) + k;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            if (mask[c]) begin
                idx = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_tree_pipe.sv
// ---------------------------------------------------------------------------
// mux_tree_pipe
// Pipelined CHANNELS:1 word multiplexer built as a two-level tree
// (GROUP:1 then CHANNELS/GROUP:1) with a valid/ready handshake on both sides,
// a DIRECT / SCAN (round-robin over a mask) / HOLD select source, and an
// enable that zeroes the selected word. Latency is two cycles.
//   clk, rst   : clock (rising edge) and synchronous active-high reset
//   data_in    : channel c at [c*WIDTH +: WIDTH]
//   sel_in     : channel index for DIRECT mode
//   mode       : select source, see mux_tree_pipe_pkg::mode_t
//   chan_mask  : SCAN eligibility, 1 = eligible
//   en         : 0 forces the beat's data to zero
//   in_valid   : upstream beat offered; in_ready : beat accepted this cycle
//   out_data   : selected word; out_sel : index that produced it
//   out_err    : the beat's index was >= CHANNELS
//   out_valid  : output beat present; out_ready : consumer accepts it
// ---------------------------------------------------------------------------
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 16,
    parameter int GROUP    = 4,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [1:0]                mode,
    input  logic [CHANNELS-1:0]       chan_mask,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int NGRP  = CHANNELS / GROUP;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    mode_t            mode_q;
    logic             s2_load;
    logic             s1_load;
    logic             accept;
    logic             scan_found;
    logic [SEL_W-1:0] scan_idx;
    logic [SEL_W-1:0] scan_ptr;
    logic [SEL_W-1:0] hold_sel;
    logic [SEL_W-1:0] eff_sel;
    logic             eff_err;
    logic [GRP_W-1:0] eff_grp;
    logic [WIDTH-1:0] lvl1_win [NGRP];

    logic             vld_p1;
    logic             en_p1;
    logic             err_p1;
    logic [SEL_W-1:0] sel_p1;
    logic [GRP_W-1:0] grp_p1;
    logic [WIDTH-1:0] win_p1 [NGRP];
    logic [WIDTH-1:0] s2_word;

    assign mode_q = mode_t'(mode);

    mux_rr_scan #(
        .CHANNELS (CHANNELS)
    ) u_scan (
        .mask  (chan_mask),
        .ptr   (scan_ptr),
        .found (scan_found),
        .idx   (scan_idx)
    );

    always_comb begin
        case (mode_q)
            MODE_SCAN: eff_sel = scan_idx;
            MODE_HOLD: eff_sel = hold_sel;
            default:   eff_sel = sel_in;
        endcase
    end

    // An out-of-range index only exists when CHANNELS is not a power of two.
    generate
        if (CHANNELS == (1 << SEL_W)) begin : g_no_err
            assign eff_err = 1'b0;
        end else begin : g_err
            assign eff_err = (int'(eff_sel) >= CHANNELS);
        end
    endgenerate

    // Handshake: no skid buffer, so readiness ripples back combinationally.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !vld_p1 || s2_load;
    assign in_ready = s1_load && !(mode_q == MODE_SCAN && !scan_found);
    assign accept   = in_valid && in_ready;

    // First tree level: every group picks its member at the low select digit.
    // An out-of-range index still yields a legal low digit; err zeroes it later.
    always_comb begin
        int lo;
        lo      = int'(eff_sel) % GROUP;
        eff_grp = GRP_W'(int'(eff_sel) / GROUP);
        for (int g = 0; g < NGRP; g++) begin
            lvl1_win[g] = data_in[(g * GROUP + lo) * WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            scan_ptr <= '0;
            hold_sel <= '0;
        end else begin
            if (s1_load) begin
                vld_p1 <= accept;
            end
            if (accept) begin
                hold_sel <= eff_sel;
                if (mode_q == MODE_SCAN) begin
                    scan_ptr <= (int'(scan_idx) == CHANNELS - 1) ? '0 : scan_idx + 1'b1;
                end
            end
        end
    end

    // ---- S1: group winners, upper select digit, en/err captured at accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            en_p1  <= en;
            err_p1 <= eff_err;
            sel_p1 <= eff_sel;
            grp_p1 <= eff_grp;
            win_p1 <= lvl1_win;
        end
    end

    // Second tree level.
    always_comb begin
        s2_word = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (grp_p1 == GRP_W'(g)) begin
                s2_word = win_p1[g];
            end
        end
        if (!en_p1 || err_p1) begin
            s2_word = '0;
        end
    end

    // ---- S2: output registers, frozen while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_data <= s2_word;
                out_sel  <= sel_p1;
                out_err  <= err_p1;
            end
        end
    end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined multi-channel data multiplexer. It is the next generation of the team's flat 16:1 enable-gated mux. It selects one of CHANNELS input words of WIDTH bits through a registered two-level tree (first level GROUP:1, second level CHANNELS/GROUP:1). It adds a valid/ready handshake, a round-robin scan mode with a channel mask, and a hold mode. It sits between the channel sources and any single-lane consumer that applies backpressure.

## Interface
- WIDTH, 1, bits per channel word
- CHANNELS, 16, number of input channels; must be a multiple of GROUP, ≥ 2
- GROUP, 4, first-level fan-in; must be ≥ 2
- SEL_W, derived localparam, $clog2(CHANNELS)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- sel_in  in  SEL_W  channel index used in DIRECT mode
- mode  in  2  00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved (behaves as DIRECT)
- chan_mask  in  CHANNELS  SCAN-mode eligibility, 1 = eligible
- en  in  1  output gate; 0 forces the beat's data to zero
- in_valid  in  1  input beat offered
- in_ready  out  1  beat accepted when in_valid & in_ready
- out_data  out  WIDTH  selected word
- out_sel  out  SEL_W  channel index that produced out_data
- out_err  out  1  beat selected an index ≥ CHANNELS
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts when out_valid & out_ready

## Operation
- Effective select for each accepted beat:
  - DIRECT/reserved: sel_in.
  - HOLD: the select of the last accepted beat (0 after reset).
  - SCAN: the first set bit of chan_mask at or after scan_ptr, searching cyclically. After acceptance, scan_ptr = chosen + 1, wrapping CHANNELS-1 → 0.
- SCAN with chan_mask all zero: in_ready = 0 and no beat is accepted. scan_ptr is unchanged.
- Index ≥ CHANNELS (possible only when CHANNELS is not a power of 2): out_data = 0 and out_err = 1 for that beat; out_sel carries the raw index.
- en is sampled with the beat. When en = 0, out_data = 0, but out_sel, out_valid and out_err flow normally.
- data_in and all controls are sampled only at acceptance. Later changes do not affect in-flight beats.
- Mode and mask changes take effect on the next accepted beat. scan_ptr persists across mode changes.
- HOLD records the select of every accepted beat, including beats accepted in HOLD mode.

## Timing
- Pipeline stage S1 registers:
  - the GROUP:1 winner of every group;
  - upper select bits;
  - en, err and valid.
- Stage S2 (output registers) performs the CHANNELS/GROUP:1 select.
- Latency: a beat accepted at edge N appears on out_* after edge N+1, i.e. out_valid is high during cycle N+2. That is 2 cycles with no stall.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall rule: S2 loads when !out_valid | out_ready. S1 loads when !s1_valid | S2 loads. in_ready = S1 loads, qualified by the SCAN empty-mask rule.
- in_ready is combinational from out_ready and the valid bits (no skid buffer).
- While stalled, out_data, out_sel, out_err and out_valid hold stable.
- Reset values: out_valid 0, out_data 0, out_sel 0, out_err 0, S1 valid 0, scan_ptr 0, hold select 0. in_ready is 1 in the cycle after reset (0 if mode = SCAN with an empty mask).
- Reset asserted mid-stream flushes all in-flight beats; none are emitted.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate a beat.

## Structure
- Package mux_tree_pipe_pkg holds:
  - the mode encoding constants MODE_DIRECT, MODE_SCAN, MODE_HOLD, MODE_RSVD;
  - the mode_t typedef.
- Sub-module mux_rr_scan (parameter CHANNELS): a combinational cyclic first-set-bit finder.
  - Inputs: mask, ptr.
  - Outputs: found, idx.
  - It is reused elsewhere for round-robin arbitration.
- The top level contains the select logic, the two pipeline stages and the handshake.

## Test plan
- DIRECT, WIDTH=8, CHANNELS=16, data_in channel c = 8'h10+c, out_ready=1, sel_in sweeping 0..15 one beat per cycle → out_data 8'h10..8'h1F in order, each out_valid exactly 2 cycles after its accept, no gaps.
- SCAN, chan_mask=16'h8421, 6 beats → out_sel sequence 0,5,10,15,0,5. Then chan_mask=0 → in_ready=0 and no further beats.
- HOLD after a DIRECT beat with sel_in=7, then sel_in toggled randomly for 3 beats → out_sel=7 and out_data=channel 7 for all 3 beats.
- Backpressure: out_ready=0 for 4 cycles with beats pending → in_ready low once S1 and S2 are full, outputs stable. Releasing out_ready delivers all beats in order, no loss or duplication.
- CHANNELS=12, GROUP=4, DIRECT sel_in=13 → out_err=1, out_data=0, out_sel=13. Same beat with en=0 and sel_in=3 → out_data=0, out_err=0.
- rst pulsed while 2 beats are in flight → next cycle out_valid=0, out_data=0, scan_ptr=0. The first post-reset SCAN beat with mask all ones selects channel 0.
